// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, defaults and helpers for the slice arbiter
package rr_arb_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 4;
    localparam int MAX_N     = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
        onehot = MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts at ptr
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] winner
);

    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N);

    logic [N-1:0]    rot;
    logic [ID_W-1:0] offs;
    logic [ID_W:0]   sum;

    // Rotating the doubled vector puts requester ptr at bit 0.
    always_comb begin
        rot  = N'({req, req} >> ptr);
        offs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = ID_W'(i);
            end
        end
    end

    assign found  = |req;
    assign sum    = {1'b0, ptr} + {1'b0, offs};
    assign winner = (sum >= N_EXT) ? ID_W'(sum - N_EXT) : sum[ID_W-1:0];

endmodule

// File: rtl/rr_slice_arbiter.sv
// rtl/rr_slice_arbiter.sv - round-robin arbiter holding each grant for a quantum
module rr_slice_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [CNT_W-1:0] quantum,
    output logic [N-1:0]     gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             slice_exp
);

    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N);

    state_t           state;
    logic [CNT_W-1:0] slice_cnt;
    logic [ID_W-1:0]  ptr;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W:0]    w_inc;
    logic [ID_W-1:0]  next_ptr;
    logic [CNT_W-1:0] q_eff;
    logic             owner_req;
    logic             rel;
    logic             expire;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    assign w_inc     = {1'b0, winner} + 1'b1;
    assign next_ptr  = (w_inc == N_EXT) ? '0 : w_inc[ID_W-1:0];
    assign q_eff     = (quantum == '0) ? CNT_W'(1) : quantum;
    assign owner_req = req[gnt_id];
    assign rel       = !owner_req;
    assign expire    = (slice_cnt == CNT_W'(1)) && owner_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            slice_exp <= 1'b0;
            slice_cnt <= '0;
            ptr       <= '0;
        end else begin
            slice_exp <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= N'(onehot(4'(winner)));
                        gnt_id    <= winner;
                        busy      <= 1'b1;
                        slice_cnt <= q_eff;
                        ptr       <= next_ptr;
                    end
                end
                GRANT: begin
                    if (!rel && !expire) begin
                        slice_cnt <= slice_cnt - 1'b1;
                    end else begin
                        slice_exp <= expire;
                        // ptr already points past the owner, so it is searched last.
                        if (found) begin
                            gnt       <= N'(onehot(4'(winner)));
                            gnt_id    <= winner;
                            slice_cnt <= q_eff;
                            ptr       <= next_ptr;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_id    <= '0;
                            busy      <= 1'b0;
                            slice_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// tb/tb_rr_slice_arbiter.sv - directed self-checking bench for rr_slice_arbiter
module tb_rr_slice_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] quantum;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       slice_exp;

    int checks = 0;
    int errors = 0;

    rr_slice_arbiter #(
        .N     (4),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .quantum   (quantum),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .slice_exp (slice_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                           input logic ee);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_id"}, 32'(gnt_id), 32'(eid));
        chk({tag, "_busy"}, 32'(busy), 32'(eg != 4'b0000));
        chk({tag, "_exp"}, 32'(slice_exp), 32'(ee));
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                        input logic ee);
        @(posedge clk);
        @(negedge clk);
        chk_all(tag, eg, eid, ee);
    endtask

    initial begin
        int o;
        rst_n   = 1'b0;
        req     = 4'b0000;
        quantum = 4'd0;
        repeat (2) @(negedge clk);
        chk_all("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;

        // All four requesting, quantum 2: two cycles each, no gaps.
        req     = 4'b1111;
        quantum = 4'd2;
        for (int k = 1; k <= 16; k++) begin
            o = ((k - 1) / 2) % 4;
            step($sformatf("all_k%0d", k), 4'(1 << o), 2'(o), (k >= 3) && (k % 2 == 1));
        end
        req = 4'b0000;
        step("all_idle", 4'b0000, 2'd0, 1'b0);

        // Owner 0 releases after one cycle; 2 takes over with a full slice.
        req     = 4'b0101;
        quantum = 4'd4;
        step("rel_g0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0100;
        step("rel_sw", 4'b0100, 2'd2, 1'b0);
        step("rel_h1", 4'b0100, 2'd2, 1'b0);
        step("rel_h2", 4'b0100, 2'd2, 1'b0);
        step("rel_h3", 4'b0100, 2'd2, 1'b0);
        step("rel_exp", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        step("rel_idle", 4'b0000, 2'd0, 1'b0);

        // Lone requester 0, quantum 3: continuous grant, expiry every 3 cycles.
        req     = 4'b0001;
        quantum = 4'd3;
        for (int k = 1; k <= 7; k++) begin
            step($sformatf("solo_k%0d", k), 4'b0001, 2'd0, (k == 4) || (k == 7));
        end
        req = 4'b0000;
        step("solo_idle", 4'b0000, 2'd0, 1'b0);

        // ptr sits at 1; the search wraps back to 0.
        req = 4'b0001;
        step("wrap_g0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step("wrap_idle", 4'b0000, 2'd0, 1'b0);

        // Quantum 0 acts as 1: owners alternate every cycle.
        req     = 4'b0011;
        quantum = 4'd0;
        step("q0_1", 4'b0010, 2'd1, 1'b0);
        step("q0_2", 4'b0001, 2'd0, 1'b1);
        step("q0_3", 4'b0010, 2'd1, 1'b1);
        step("q0_4", 4'b0001, 2'd0, 1'b1);

        // Quantum 3 sampled at grant start; change to 5 mid-slice applies next.
        quantum = 4'd3;
        step("qc_g1", 4'b0010, 2'd1, 1'b1);
        quantum = 4'd5;
        step("qc_h1", 4'b0010, 2'd1, 1'b0);
        step("qc_h2", 4'b0010, 2'd1, 1'b0);
        step("qc_g0", 4'b0001, 2'd0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("qc_h0_%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        step("qc_next", 4'b0010, 2'd1, 1'b1);

        // Owner 1 drops while 2 asks: same-edge handover.
        req = 4'b0100;
        step("hand_g2", 4'b0100, 2'd2, 1'b0);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1100;
        @(negedge clk);
        chk_all("rst_held", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step("post_rst", 4'b0100, 2'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_slice_arbiter.md
Name: rr_slice_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesters, holding each grant for a programmable time slice (quantum) instead of a single cycle. A grant ends when the slice expires or the owner drops its request, then passes round-robin with no idle cycle. It sits between requester masters and the shared resource mux, and its one-hot grant drives the mux select.

Parameters:
N, 4, number of requesters (2..16)
CNT_W, 4, width of quantum and slice counter
ID_W, $clog2(N), width of gnt_id

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  N  request vector; req[i] held high while requester i wants the resource
quantum  in  CNT_W  slice length in cycles; sampled only when a grant starts; 0 treated as 1
gnt  out  N  registered one-hot grant, all-zero when idle
gnt_id  out  ID_W  binary index of current owner; 0 when idle
busy  out  1  registered; equals |gnt
slice_exp  out  1  registered one-cycle pulse in the first cycle after a grant ended by quantum expiry

Behaviour:
- Reset: gnt=0, gnt_id=0, busy=0, slice_exp=0, state=IDLE, slice_cnt=0, ptr=0 (requester 0 has highest priority first). All of these clear asynchronously, including during an active grant.
- States: IDLE, GRANT.
- Pick function: first i with req[i]=1, searching ptr, ptr+1, ..., ptr+N-1 mod N.
- IDLE:
  - If |req at an edge, go to GRANT with winner w. Set gnt=1<<w and gnt_id=w.
  - Load slice_cnt=max(quantum,1).
  - Set ptr=(w+1) mod N.
  - Latency is 1 cycle from req to gnt.
- GRANT, owner o, evaluated at each edge:
  - release = !req[o]. expire = (slice_cnt==1) && req[o].
  - Neither: hold the grant and decrement slice_cnt.
  - release or expire: re-pick with the pick function using current ptr (=o+1).
    - o is searched last.
    - On release, o is excluded because req[o]=0.
  - Winner found: switch gnt/gnt_id to the winner in the same edge, with no bubble. Reload slice_cnt from quantum and set ptr=winner+1.
  - No winner: go to IDLE, gnt=0. ptr is unchanged.
- Expiry with only o requesting: o is re-granted. gnt stays high continuously, slice_cnt reloads, and slice_exp pulses.
- slice_exp=1 for exactly one cycle after any edge where expire was true, whether or not ownership changed. It is 0 for release-ended grants.
- A grant with quantum Q and req held lasts exactly Q cycles of gnt high.
- Changes to quantum during a slice have no effect until the next grant start.
- Simultaneous release by the owner and new requests elsewhere: normal round-robin pick, no idle cycle.
- gnt is always one-hot or zero. gnt_id and gnt always agree.
- A request dropped by a non-owner before it is granted is simply never granted.
- Counter width: slice_cnt is CNT_W bits. Max slice is 2^CNT_W-1 cycles. No wrap is possible because the counter reloads at 1.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum (IDLE, GRANT)
  - default N / CNT_W constants
  - a function onehot(idx)
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[N], ptr[ID_W].
  - Outputs: found, winner[ID_W].
  - Implemented with a double-width mask / rotate.
  - Instantiated once; the FSM, counter and ptr stay in rr_slice_arbiter.

Test Plan:
- Reset then req=4'b0001, quantum=3, held: gnt=0001 from cycle 1, held continuously; slice_exp pulses every 3 cycles; gnt_id=0; busy=1.
- req=4'b1111, quantum=2, held 16 cycles: gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000 repeating, with no zero cycles between owners.
- req=4'b0101, quantum=4; owner 0 drops req after 1 granted cycle: gnt=0001 for 1 cycle, then 0100 for 4 cycles; slice_exp=0 after the first grant and 1 after the second.
- Single grant ends and no requests remain: gnt=0001 then 0000 with busy=0; a later req=4'b0001 re-grants 0 (ptr=1, wraps to 0) after 1 cycle latency.
- quantum=0 with req=4'b0011: each owner holds 1 cycle and gnt alternates 0001/0010. Changing quantum to 5 mid-grant affects only the following grant.
- Assert rst_n=0 mid-grant with gnt=0100: gnt, busy and slice_exp go to 0 immediately, without waiting for clk. After release, req=4'b1100 is granted to 2 first (ptr reset to 0).
